// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory request/response interface.
// Used by both the responder and the requester side of the core.
package data_mem_responder_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_ACCESS = 1'b1;

    // Misaligned word access or any address bit set above the array's word range.
    function automatic logic addr_err(input logic [DATA_W-1:0] addr, input int unsigned aw);
        if (addr[1:0] != 2'b00) return ERR_ACCESS;
        if ((addr >> (aw + 2)) != '0) return ERR_ACCESS;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Word-organised data memory: synchronous write, combinational read.
// Contents are intentionally not reset.
module dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: accepts a load/store, waits LATENCY
// cycles, performs the access and holds the response until it is taken.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data;
    logic              acc_err;
    logic              access;
    logic              mem_we;

    assign acc_err = addr_err(addr_q, AW);
    assign access  = (state == S_WAIT) && (cnt == '0);
    assign mem_we  = access && we_q && (acc_err == ERR_NONE);

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .rdata (rd_data)
    );

    // Gated by rst_n so the requester sees ready low for the whole reset window.
    assign req_ready = rst_n && (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= CW'(LATENCY - 1);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (we_q || (acc_err != ERR_NONE)) ? '0 : rd_data;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= ERR_NONE;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
